button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable clk cycles required to accept a level change (legal range 2..2^20).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1; 1 means btn_raw=0 is "pressed", 0 means btn_raw=1 is "pressed".
REQ-003 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port btn_raw  input  1  asynchronous, bouncing push-button pin.
REQ-006 SHALL have port btn_level  output  1  debounced level, 1 = pressed.
REQ-007 SHALL have port btn_press  output  1  one-cycle pulse on accepted press; drives the downstream delay stage / counter enable.
REQ-008 SHALL have port btn_release  output  1  one-cycle pulse on accepted release.

Function
REQ-009 SHALL pass btn_raw through a 2-flop synchronizer, then normalise polarity per ACTIVE_LOW; the result is "s" (1 = pressed).
REQ-010 SHALL implement FSM states IDLE (stable released), PRESS_WAIT, HELD (stable pressed), RELEASE_WAIT.
REQ-011 IDLE -> PRESS_WAIT when s=1; counter cleared on entry.
REQ-012 PRESS_WAIT: counter increments each cycle s=1; s=0 in any cycle -> IDLE, counter cleared, no pulse (bounce rejected).
REQ-013 PRESS_WAIT -> HELD when counter reaches DEBOUNCE_CYCLES-1 with s=1; btn_press=1 and btn_level=1 registered on that same edge.
REQ-014 HELD -> RELEASE_WAIT when s=0; RELEASE_WAIT mirrors REQ-012/013 with s=0 counting, s=1 aborting back to HELD; acceptance -> IDLE with btn_release=1, btn_level=0.
REQ-015 Latency: btn_raw stably pressed from before edge N -> btn_press high for exactly one cycle starting at edge N+2+DEBOUNCE_CYCLES; release symmetric.
REQ-016 btn_press and btn_release SHALL be high for one cycle only, never simultaneously, and only on FSM transitions into HELD / IDLE respectively.
REQ-017 btn_level SHALL change only together with a btn_press/btn_release pulse.
REQ-018 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL never wrap (saturation impossible by REQ-013/014).
REQ-019 A held button SHALL produce exactly one btn_press regardless of hold duration (no auto-repeat).

Reset
REQ-020 On rst=1 at an edge: FSM -> IDLE, counter=0, btn_level=0, btn_press=0, btn_release=0, synchronizer flops = "released" level per ACTIVE_LOW.
REQ-021 Reset mid-debounce SHALL abort silently; no pulse during or in the cycle after reset.
REQ-022 A button held through reset SHALL be re-debounced after rst deasserts and yield one btn_press per REQ-015.

Structure
REQ-023 Package btn_pkg SHALL hold the FSM state enum and a default DEBOUNCE_CYCLES constant.
REQ-024 The synchronizer SHALL be sub-module sync_2ff (clk, rst, reset value parameter, d, q); the FSM and counter live in button_conditioner.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-025 Clean press: btn_raw 1->0 before edge 10, held -> btn_press high only in cycle after edge 16, btn_level=1 from edge 16.
REQ-026 Bounce: btn_raw 0 for 2 cycles, 1 for 1, then 0 held -> no pulse for the glitch; single btn_press 6 cycles after the final falling sample.
REQ-027 Release: after HELD, btn_raw 0->1 held -> one btn_release 6 cycles later, btn_level=0; a 1-cycle release glitch produces no pulse.
REQ-028 Long hold 1000 cycles -> exactly one btn_press, zero btn_release until release.
REQ-029 rst asserted mid-PRESS_WAIT -> no pulse, outputs 0; button still held -> btn_press 6 cycles after rst deasserts.
REQ-030 Polarity: ACTIVE_LOW=0, btn_raw 0->1 held -> btn_press per REQ-015.

Source files
------------

// File: rtl/btn_pkg.sv
// ============================================================================
// btn_pkg : shared types and defaults for the push-button conditioner
// Rev 1.0
// ============================================================================
`default_nettype none

package btn_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // Maps the raw pin level onto "1 = pressed" for either board wiring.
   function automatic logic pressed_level(input logic raw, input bit active_low);
      return active_low ? ~raw : raw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchronizer with a selectable reset level
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner : synchronises and debounces a push-button, emits level
//                      plus one-cycle press/release pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module button_conditioner
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_sync;
   logic             s;
   btn_state_t       state;
   logic [CNT_W-1:0] cnt;

   // Reset value is the idle (released) pin level so no false press follows reset.
   sync_2ff #(
      .RESET_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw),
      .q   (btn_sync)
   );

   assign s = pressed_level(btn_sync, ACTIVE_LOW);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         case (state)
            IDLE: begin
               if (s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state     <= HELD;
                  cnt       <= '0;
                  btn_press <= 1'b1;
                  btn_level <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (!s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state       <= IDLE;
                  cnt         <= '0;
                  btn_release <= 1'b1;
                  btn_level   <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// tb_button_conditioner : randomized + directed bench for button_conditioner
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

   localparam int D   = 4;
   localparam int LAT = D + 3;  // negedges from driving the pin to seeing the pulse

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic raw_a = 1'b1;
   logic raw_b = 1'b0;
   logic level_a, press_a, rel_a;
   logic level_b, press_b, rel_b;

   always #5 clk = ~clk;

   button_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_a (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (raw_a),
      .btn_level   (level_a),
      .btn_press   (press_a),
      .btn_release (rel_a)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (raw_b),
      .btn_level   (level_b),
      .btn_press   (press_b),
      .btn_release (rel_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the pressed sample reaches the decision point two edges
   // after capture; the level flips once the seen value has disagreed with it
   // for D+1 consecutive edges.
   bit m_pipe [2][$];
   int m_run   [2];
   bit m_level [2];
   bit m_press [2];
   bit m_rel   [2];
   bit model_ok = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit now_p, seen;
         now_p = (i == 0) ? !raw_a : raw_b;
         if (rst) begin
            m_pipe[i].delete();
            m_pipe[i].push_back(1'b0);
            m_pipe[i].push_back(1'b0);
            m_run[i]   = 0;
            m_level[i] = 1'b0;
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
         end else begin
            seen = m_pipe[i].pop_front();
            m_pipe[i].push_back(now_p);
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            m_run[i]   = (seen != m_level[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == D + 1) begin
               m_level[i] = !m_level[i];
               m_press[i] = m_level[i];
               m_rel[i]   = !m_level[i];
               m_run[i]   = 0;
            end
         end
      end
      if (rst) model_ok = 1'b1;
   end

   int cnt_press_a = 0;
   int cnt_rel_a   = 0;

   always @(negedge clk) begin
      if (model_ok) begin
         check("level_a",   level_a, m_level[0]);
         check("press_a",   press_a, m_press[0]);
         check("release_a", rel_a,   m_rel[0]);
         check("level_b",   level_b, m_level[1]);
         check("press_b",   press_b, m_press[1]);
         check("release_b", rel_b,   m_rel[1]);
         if (press_a) cnt_press_a++;
         if (rel_a)   cnt_rel_a++;
      end
   end

   // Bounded wait for a pulse; the number of negedges waited is the latency.
   task automatic measure(input string tag, input int sel, input int exp);
      int   n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 40) begin
         @(negedge clk);
         n++;
         case (sel)
            0:       hit = press_a;
            1:       hit = rel_a;
            2:       hit = press_b;
            default: hit = rel_b;
         endcase
      end
      check(tag, n, exp);
   endtask

   initial begin
      int p0, r0, len;
      logic va, vb;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_level", level_a, 1'b0);
      check("rst_press", press_a, 1'b0);
      check("rst_rel",   rel_a,   1'b0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // clean press then long hold: exactly one press, no release
      p0 = cnt_press_a;
      r0 = cnt_rel_a;
      raw_a = 1'b0;
      measure("press_latency", 0, LAT);
      repeat (1000) @(negedge clk);
      check("hold_presses",  cnt_press_a - p0, 1);
      check("hold_releases", cnt_rel_a - r0,   0);
      check("hold_level",    level_a, 1'b1);

      // one-cycle release glitch must be ignored
      raw_a = 1'b1;
      @(negedge clk);
      raw_a = 1'b0;
      repeat (12) @(negedge clk);
      check("glitch_rel", cnt_rel_a - r0, 0);
      check("glitch_lvl", level_a, 1'b1);

      raw_a = 1'b1;
      measure("release_latency", 1, LAT);
      check("release_level", level_a, 1'b0);
      repeat (4) @(negedge clk);

      // press bounce: 0,0,1 then held low
      raw_a = 1'b0;
      repeat (2) @(negedge clk);
      raw_a = 1'b1;
      @(negedge clk);
      raw_a = 1'b0;
      measure("bounce_latency", 0, LAT);
      raw_a = 1'b1;
      repeat (12) @(negedge clk);

      // reset during PRESS_WAIT with the button still held
      raw_a = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_level", level_a, 1'b0);
      check("midrst_press", press_a, 1'b0);
      rst = 1'b0;
      measure("post_rst_latency", 0, LAT);
      raw_a = 1'b1;
      repeat (12) @(negedge clk);

      // active-high polarity instance
      raw_b = 1'b1;
      measure("polarity_press", 2, LAT);
      raw_b = 1'b0;
      measure("polarity_release", 3, LAT);

      // random bouncing runs on both pins
      for (int k = 0; k < 400; k++) begin
         len = int'($urandom_range(1, 9));
         va  = logic'($urandom_range(0, 1));
         vb  = logic'($urandom_range(0, 1));
         raw_a = va;
         raw_b = vb;
         repeat (len) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
